reg_bank_swapper: RTL and testbench
===================================

Name: reg_bank_swapper

Overview:
- Parametrised bank of DEPTH registers, each WIDTH bits, with a single command port for write, swap and rotate.
- Two swap implementations are selectable by parameter:
  - temp-register swap, sequential, 3 cycles;
  - parallel swap, single cycle, non-blocking style.
- Used as a reusable permutation/reorder store feeding datapath blocks. Contents are readable combinationally at any time.

Parameters:
- WIDTH, 4, bits per entry (1..32).
- DEPTH, 4, number of entries (2..16, need not be a power of 2).
- IDX_W, 4, index width; must satisfy 2**IDX_W >= DEPTH.
- TEMP_SWAP, 1, 1 = swap via internal temp register in 3 cycles; 0 = parallel swap in 1 cycle.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  command: 0 WRITE, 1 SWAP, 2 ROTATE, 3 NOP.
- cmd_idx_a  in  IDX_W  WRITE target / SWAP first index.
- cmd_idx_b  in  IDX_W  SWAP second index.
- cmd_wdata  in  WIDTH  WRITE data.
- rd_idx  in  IDX_W  read index.
- rd_data  out  WIDTH  regs[rd_idx], combinational; 0 if rd_idx >= DEPTH.
- done  out  1  one-cycle pulse on command completion.
- cmd_err  out  1  qualifies done: command rejected (index out of range).
- busy  out  1  ~cmd_ready.

Behaviour:
- Reset (async, rst=1):
  - entry i = (i+1) mod 2**WIDTH;
  - temp = 0;
  - state = IDLE;
  - cmd_ready = 1, done = 0, cmd_err = 0.
- Reset asserted mid-swap aborts the swap. All entries return to their reset values; no partial swap state survives.
- Handshake:
  - Accept on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = 1 only in IDLE.
  - Command inputs are sampled only at acceptance.
- States: IDLE, MOVE_A, MOVE_B (the last two exist only when TEMP_SWAP=1).
- WRITE:
  - At the accept edge, regs[a] <= wdata.
  - done = 1 in the following cycle; the new value is visible on rd_data in that same cycle.
- SWAP, TEMP_SWAP=0:
  - At the accept edge, regs[a] <= regs[b] and regs[b] <= regs[a], both from pre-edge values.
  - done next cycle; the block stays in IDLE.
- SWAP, TEMP_SWAP=1:
  - Accept edge: temp <= regs[a]; IDLE -> MOVE_A.
  - MOVE_A edge: regs[a] <= regs[b]; -> MOVE_B.
  - MOVE_B edge: regs[b] <= temp; -> IDLE.
  - done is high in the cycle after the MOVE_B edge; cmd_ready is high in that same cycle.
  - Total 3 edges; cmd_ready is low for exactly 2 cycles.
- SWAP with a == b: follows the same timing, contents unchanged, done pulses.
- ROTATE:
  - Single cycle: regs[k] <= regs[k+1] for k < DEPTH-1, and regs[DEPTH-1] <= regs[0].
  - done next cycle.
- NOP: done pulses next cycle; no state change.
- Out-of-range index: any used index >= DEPTH (idx_a for WRITE; idx_a or idx_b for SWAP).
  - Command is accepted but has no effect on contents.
  - done = 1 and cmd_err = 1 for one cycle; no multi-cycle sequence is entered.
- cmd_err is 0 whenever done is 0.
- Back-to-back commands: a new command may be accepted in the same cycle done is high.

Optional Feature:
- Macro SWAP_COUNT_EN.
- When defined, adds output swap_count [15:0]:
  - resets to 0;
  - increments by 1 on the completion edge of each valid SWAP, including a == b;
  - wraps 0xFFFF -> 0;
  - does not count WRITE, ROTATE, NOP or errored commands.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, DEPTH=4, WIDTH=4 -> rd_data for idx 0..3 reads 1, 2, 3, 4; cmd_ready=1, done=0.
- TEMP_SWAP=1, SWAP a=0, b=1 -> cmd_ready low 2 cycles; done on the 3rd cycle after accept; entries read 2, 1, 3, 4; swap_count=1 (SWAP_COUNT_EN).
- TEMP_SWAP=0, SWAP a=2, b=3, then immediately ROTATE -> after the swap entries read 1, 2, 4, 3; after the rotate 2, 4, 3, 1; two consecutive done pulses.
- WRITE a=1, data=0xF, then SWAP a=1, b=1 -> entries 1, 15, 3, 4, unchanged by the swap; done pulses; swap_count increments.
- SWAP a=0, b=5 with DEPTH=4 -> done=1 and cmd_err=1 for one cycle; contents unchanged; no count.
- rst pulsed during MOVE_A of a temp swap of 0 and 3 -> entries return to 1, 2, 3, 4; state IDLE; swap_count=0.

Source files
------------

// File: rtl/reg_bank_swapper.sv
// Register bank with a single write/swap/rotate command port and combinational read.
// Optional feature macro SWAP_COUNT_EN adds the 16-bit swap_count output.
module reg_bank_swapper #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned IDX_W     = 4,
   parameter int unsigned TEMP_SWAP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [IDX_W-1:0] cmd_idx_a,
   input  logic [IDX_W-1:0] cmd_idx_b,
   input  logic [WIDTH-1:0] cmd_wdata,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data,
   output logic             done,
   output logic             cmd_err,
`ifdef SWAP_COUNT_EN
   output logic [15:0]      swap_count,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVE_A = 2'd1,
      MOVE_B = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'd0,
      OP_SWAP   = 2'd1,
      OP_ROTATE = 2'd2,
      OP_NOP    = 2'd3
   } op_e;

   localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   regs_q [DEPTH];
   logic [WIDTH-1:0]   regs_d [DEPTH];
   logic [WIDTH-1:0]   temp_q, temp_d;
   logic [IDX_W-1:0]   a_q, a_d;
   logic [IDX_W-1:0]   b_q, b_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
`ifdef SWAP_COUNT_EN
   logic [15:0]        count_q, count_d;
`endif

   logic [WIDTH-1:0]   val_a, val_b, held_b;
   logic               a_ok, b_ok;

   // Index decode by comparison keeps non-power-of-2 depths free of out-of-bounds selects.
   always_comb begin
      rd_data = '0;
      val_a   = '0;
      val_b   = '0;
      held_b  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (rd_idx == IDX_W'(k))    rd_data = regs_q[k];
         if (cmd_idx_a == IDX_W'(k)) val_a   = regs_q[k];
         if (cmd_idx_b == IDX_W'(k)) val_b   = regs_q[k];
         if (b_q == IDX_W'(k))       held_b  = regs_q[k];
      end
   end

   assign a_ok = ({1'b0, cmd_idx_a} < DEPTH_X);
   assign b_ok = ({1'b0, cmd_idx_b} < DEPTH_X);

   always_comb begin
      state_d = state_q;
      regs_d  = regs_q;
      temp_d  = temp_q;
      a_d     = a_q;
      b_d     = b_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
`ifdef SWAP_COUNT_EN
      count_d = count_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               done_d = 1'b1;
               case (op_e'(cmd_op))
                  OP_WRITE: begin
                     if (!a_ok) begin
                        err_d = 1'b1;
                     end else begin
                        for (int unsigned k = 0; k < DEPTH; k++)
                           if (cmd_idx_a == IDX_W'(k)) regs_d[k] = cmd_wdata;
                     end
                  end
                  OP_SWAP: begin
                     if (!(a_ok && b_ok)) begin
                        err_d = 1'b1;
                     end else if (TEMP_SWAP != 0) begin
                        temp_d  = val_a;
                        a_d     = cmd_idx_a;
                        b_d     = cmd_idx_b;
                        state_d = MOVE_A;
                        done_d  = 1'b0;
                     end else begin
                        for (int unsigned k = 0; k < DEPTH; k++) begin
                           if (cmd_idx_b == IDX_W'(k)) regs_d[k] = val_a;
                           if (cmd_idx_a == IDX_W'(k)) regs_d[k] = val_b;
                        end
`ifdef SWAP_COUNT_EN
                        count_d = count_q + 16'd1;
`endif
                     end
                  end
                  OP_ROTATE: begin
                     for (int unsigned k = 0; k < DEPTH; k++)
                        regs_d[k] = regs_q[(k + 1) % DEPTH];
                  end
                  default: ;
               endcase
            end
         end
         MOVE_A: begin
            for (int unsigned k = 0; k < DEPTH; k++)
               if (a_q == IDX_W'(k)) regs_d[k] = held_b;
            state_d = MOVE_B;
         end
         MOVE_B: begin
            for (int unsigned k = 0; k < DEPTH; k++)
               if (b_q == IDX_W'(k)) regs_d[k] = temp_q;
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef SWAP_COUNT_EN
            count_d = count_q + 16'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         for (int unsigned k = 0; k < DEPTH; k++)
            regs_q[k] <= WIDTH'(k + 1);
         temp_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef SWAP_COUNT_EN
         count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
         temp_q  <= temp_d;
         a_q     <= a_d;
         b_q     <= b_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef SWAP_COUNT_EN
         count_q <= count_d;
`endif
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = ~cmd_ready;
   assign done      = done_q;
   assign cmd_err   = err_q;
`ifdef SWAP_COUNT_EN
   assign swap_count = count_q;
`endif

endmodule

// File: tb/tb_reg_bank_swapper.sv
// Random + directed bench for reg_bank_swapper: instance 0 uses temp swap, instance 1 parallel swap.
`timescale 1ns/1ps
module tb_reg_bank_swapper;

   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      v, rdy, dn, er, bz;
   logic [1:0][1:0] op;
   logic [1:0][3:0] ia, ib, wd, ri, rdd;
`ifdef SWAP_COUNT_EN
   logic [1:0][15:0] sc;
`endif

   int unsigned mdl [2][DEPTH];
   int unsigned mcnt [2];
   int n_vec = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   reg_bank_swapper #(.WIDTH(4), .DEPTH(DEPTH), .IDX_W(4), .TEMP_SWAP(1)) u_seq (
      .clk(clk), .rst(rst), .cmd_valid(v[0]), .cmd_ready(rdy[0]), .cmd_op(op[0]),
      .cmd_idx_a(ia[0]), .cmd_idx_b(ib[0]), .cmd_wdata(wd[0]), .rd_idx(ri[0]),
      .rd_data(rdd[0]), .done(dn[0]), .cmd_err(er[0]),
`ifdef SWAP_COUNT_EN
      .swap_count(sc[0]),
`endif
      .busy(bz[0]));

   reg_bank_swapper #(.WIDTH(4), .DEPTH(DEPTH), .IDX_W(4), .TEMP_SWAP(0)) u_par (
      .clk(clk), .rst(rst), .cmd_valid(v[1]), .cmd_ready(rdy[1]), .cmd_op(op[1]),
      .cmd_idx_a(ia[1]), .cmd_idx_b(ib[1]), .cmd_wdata(wd[1]), .rd_idx(ri[1]),
      .rd_data(rdd[1]), .done(dn[1]), .cmd_err(er[1]),
`ifdef SWAP_COUNT_EN
      .swap_count(sc[1]),
`endif
      .busy(bz[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < DEPTH; k++) mdl[d][k] = (k + 1) % 16;
         mcnt[d] = 0;
      end
   endtask

   // Sweeps every entry plus two out-of-range read indices; takes 6 ns.
   task automatic check_contents(input int d, input string tag);
      int idx [6] = '{0, 1, 2, 3, 4, 15};
      for (int i = 0; i < 6; i++) begin
         ri[d] = 4'(idx[i]);
         #1;
         check($sformatf("%s d%0d rd[%0d]", tag, d, idx[i]), 32'(rdd[d]),
               (idx[i] < DEPTH) ? mdl[d][idx[i]] : 32'd0);
      end
`ifdef SWAP_COUNT_EN
      check($sformatf("%s d%0d swap_count", tag, d), 32'(sc[d]), mcnt[d]);
`endif
   endtask

   // Call in an idle/done cycle after its falling edge; returns in the done cycle.
   task automatic run_cmd(input int d, input logic [1:0] o, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] w, input string tag);
      logic        err;
      int          lat;
      int unsigned t, old [DEPTH];
      err = (o == 2'd0 && a >= DEPTH) || (o == 2'd1 && (a >= DEPTH || b >= DEPTH));
      lat = (o == 2'd1 && !err && d == 0) ? 3 : 1;
      op[d] = o; ia[d] = a; ib[d] = b; wd[d] = w; v[d] = 1'b1;
      @(posedge clk);
      #1;
      v[d] = 1'b0;
      op[d] = 2'($urandom); ia[d] = 4'($urandom); ib[d] = 4'($urandom); wd[d] = 4'($urandom);
      if (!err) begin
         case (o)
            2'd0: mdl[d][a] = 32'(w);
            2'd1: begin
               t = mdl[d][a]; mdl[d][a] = mdl[d][b]; mdl[d][b] = t;
               mcnt[d] = (mcnt[d] + 1) % 65536;
            end
            2'd2: begin
               for (int k = 0; k < DEPTH; k++) old[k] = mdl[d][k];
               for (int k = 0; k < DEPTH; k++) mdl[d][k] = old[(k + 1) % DEPTH];
            end
            default: ;
         endcase
      end
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c < lat) begin
            check({tag, " busy done"}, 32'(dn[d]), 32'd0);
            check({tag, " busy err"}, 32'(er[d]), 32'd0);
            check({tag, " busy ready"}, 32'(rdy[d]), 32'd0);
            check({tag, " busy flag"}, 32'(bz[d]), 32'd1);
         end else begin
            check({tag, " done"}, 32'(dn[d]), 32'd1);
            check({tag, " err"}, 32'(er[d]), 32'(err));
            check({tag, " ready"}, 32'(rdy[d]), 32'd1);
            check({tag, " busy"}, 32'(bz[d]), 32'd0);
         end
      end
      check_contents(d, tag);
   endtask

   task automatic idle_gap(input int d);
      @(negedge clk);
      check("gap done", 32'(dn[d]), 32'd0);
      check("gap err", 32'(er[d]), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ra, rb;
      int         d;
      rst = 1'b1; v = '0; op = '0; ia = '0; ib = '0; wd = '0; ri = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("reset ready", 32'(rdy[i]), 32'd1);
         check("reset done", 32'(dn[i]), 32'd0);
         check("reset err", 32'(er[i]), 32'd0);
         check_contents(i, "reset");
      end

      run_cmd(0, 2'd1, 4'd0, 4'd1, 4'd0, "tswap01");
      idle_gap(0);
      run_cmd(1, 2'd1, 4'd2, 4'd3, 4'd0, "pswap23");
      run_cmd(1, 2'd2, 4'd0, 4'd0, 4'd0, "prot");
      idle_gap(1);
      run_cmd(0, 2'd0, 4'd1, 4'd0, 4'hF, "wr1");
      run_cmd(0, 2'd1, 4'd1, 4'd1, 4'd0, "tswap11");
      run_cmd(1, 2'd1, 4'd3, 4'd3, 4'd0, "pswap33");
      run_cmd(0, 2'd1, 4'd0, 4'd5, 4'd0, "tswap05");
      run_cmd(1, 2'd1, 4'd0, 4'd5, 4'd0, "pswap05");
      run_cmd(0, 2'd0, 4'd7, 4'd0, 4'h9, "wr7");
      run_cmd(1, 2'd3, 4'd0, 4'd0, 4'd0, "nop");

      // Reset during MOVE_A of a temp swap of entries 0 and 3.
      op[0] = 2'd1; ia[0] = 4'd0; ib[0] = 4'd3; v[0] = 1'b1;
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      @(negedge clk);
      check("moveA ready", 32'(rdy[0]), 32'd0);
      check_contents(0, "moveA");
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         check("midrst ready", 32'(rdy[i]), 32'd1);
         check("midrst done", 32'(dn[i]), 32'd0);
         check_contents(i, "midrst");
      end
      @(negedge clk);

      for (int n = 0; n < 240; n++) begin
         d  = int'($urandom_range(0, 1));
         ra = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         rb = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         run_cmd(d, 2'($urandom_range(0, 3)), ra, rb, 4'($urandom), "rnd");
         if ($urandom_range(0, 2) == 0) idle_gap(d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
